day_line_sequencer: RTL and testbench
=====================================

Name: day_line_sequencer

Overview:
Controller that drives the existing `day` calibration core (per-character ASCII input, 16-bit two-ASCII-digit result) from a raw puzzle byte stream.
It buffers each input line, resets the core, and replays the line into the core back-to-back, one character per clock.
It then converts the core's ASCII result to binary and accumulates the puzzle sum.
This replaces the bench-side line loop, so the whole puzzle runs in hardware.

Parameters:
MAX_LINE, 64, line buffer depth in bytes; longer lines are truncated.
SETTLE_CYCLES, 1, cycles the core is held idle after the last character before its result is sampled (1..15).
SUM_W, 32, width of the accumulated sum.
CNT_W, 16, width of the line and error counters.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
s_data  in  8  input byte stream (ASCII)
s_valid  in  1  s_data valid
s_ready  out  1  sequencer accepts byte this cycle
s_last  in  1  final byte of puzzle input, qualified by s_valid
core_rst_n  out  1  reset to `day` core, active-low, registered
core_char  out  8  character to `day` core input_char, registered
core_result  in  16  `day` result_out: [15:8] tens ASCII, [7:0] units ASCII
sum_out  out  SUM_W  running sum of line values
line_count  out  CNT_W  non-empty lines processed
err_count  out  CNT_W  lines whose result was not two ASCII digits
trunc_flag  out  1  sticky: at least one line exceeded MAX_LINE
busy  out  1  high in every state except LOAD-with-empty-buffer and DONE
done  out  1  high once the last line is captured; held until rst

Behaviour:
- Reset (rst=1 at posedge) forces:
  - state LOAD, wr_ptr=0, last_seen=0
  - sum_out=0, line_count=0, err_count=0, trunc_flag=0, done=0
  - core_rst_n=0, core_char=0x00, s_ready=0 for the reset cycle
- Reset mid-operation aborts the current line; buffered data is discarded.
- Handshake: a byte transfers when s_valid && s_ready. s_ready=1 only in LOAD.
- LOAD:
  - 0x0D is accepted and dropped.
  - 0x0A ends the line.
  - Any other byte is written to buf[wr_ptr] and wr_ptr increments. If wr_ptr==MAX_LINE, the byte is accepted and dropped, and trunc_flag is set.
  - A line ends on a 0x0A transfer, or on any transfer with s_last=1 (a non-newline byte carrying s_last is stored first). s_last sets last_seen.
  - End of line with wr_ptr==0 (empty line): no core activity and no count; stay in LOAD, or go to DONE if last_seen.
  - End of line with wr_ptr>0: go to CLEAR next cycle.
- CLEAR: exactly 1 cycle; core_rst_n=0, core_char=0x00, rd_ptr=0 → FEED.
- FEED:
  - core_rst_n=1; core_char=buf[rd_ptr] on consecutive cycles, no gaps.
  - Lasts exactly wr_ptr cycles (the stored length) → SETTLE.
  - The core has no enable, so characters are never stalled or repeated.
- SETTLE: core_char=0x00 for SETTLE_CYCLES cycles → CAPTURE.
- CAPTURE (1 cycle): sample core_result.
  - Valid result: both bytes in 0x30..0x39. value = 10*(hi-0x30)+(lo-0x30), range 0..99. sum_out += value, wrapping modulo 2^SUM_W.
  - Invalid result: value=0 and err_count increments.
  - line_count increments in both cases; wr_ptr=0.
  - Next state: DONE if last_seen, else LOAD.
- DONE: done=1, s_ready=0, core_rst_n=0; exit only via rst.
- Counters saturate at all-ones; they do not wrap.
- core_char/core_rst_n are registered, so the core sees each FEED byte on the posedge after it is driven. The bench checks sequence and count, not absolute cycle alignment.
- Line latency, from the end-of-line transfer to the sum_out update: 1 (CLEAR) + len + SETTLE_CYCLES + 1 cycles.

Test Plan:
- Stream "1abc2\npqr3stu8vwx\na1b2c3d4e5f\ntreb7uchet" (s_last on final 't'), PART=1 core → sum_out=142, line_count=4, err_count=0, done=1.
- PART=2 core, "two1nine\neightwothree\nabcone2threexyz\n" (s_last on final 0x0A) → sum_out=29+83+13=125, line_count=3.
- "12\n\n\r\n34\n" with CRs and empty lines → sum_out=46, line_count=2. core_rst_n never pulses for the empty lines.
- MAX_LINE=8, line "a1bcdefgh9\n" → only "a1bcdefg" fed (FEED lasts exactly 8 cycles); trunc_flag=1; sum_out=11.
- Line "abc\n" (core returns non-digit result) → err_count=1, sum_out unchanged, line_count=1.
- Assert rst=1 during FEED of "5x5\n", then send "77\n" → first line lost, sum_out=77, line_count=1. s_valid stalls inserted randomly in LOAD do not alter results.

Source files
------------

// File: rtl/day_line_sequencer.sv
// Line sequencer for the `day` calibration core: buffers each input line, replays it
// into the core after a core reset, and accumulates the two-digit results.
module day_line_sequencer #(
  parameter int MAX_LINE      = 64,
  parameter int SETTLE_CYCLES = 1,
  parameter int SUM_W         = 32,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_last,
  output logic             core_rst_n,
  output logic [7:0]       core_char,
  input  logic [15:0]      core_result,
  output logic [SUM_W-1:0] sum_out,
  output logic [CNT_W-1:0] line_count,
  output logic [CNT_W-1:0] err_count,
  output logic             trunc_flag,
  output logic             busy,
  output logic             done
);

  localparam int PTR_W = $clog2(MAX_LINE + 1);
  localparam int IDX_W = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;
  localparam logic [PTR_W-1:0] MAX_PTR     = PTR_W'(MAX_LINE);
  localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [7:0]       CHAR_CR     = 8'h0D;
  localparam logic [7:0]       CHAR_LF     = 8'h0A;

  typedef enum logic [2:0] {
    ST_LOAD, ST_CLEAR, ST_FEED, ST_SETTLE, ST_CAPTURE, ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]       settle_cnt_q, settle_cnt_d;
  logic             last_seen_q, last_seen_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] line_count_q, line_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             trunc_q, trunc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             s_ready_q, s_ready_d;
  logic             core_rst_n_q, core_rst_n_d;
  logic [7:0]       core_char_q, core_char_d;

  logic [7:0]       buf_q [MAX_LINE];
  logic             buf_we;
  logic             xfer;
  logic             result_ok;
  logic [6:0]       line_value;

  function automatic logic is_ascii_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  assign xfer       = s_valid && s_ready_q;
  assign result_ok  = is_ascii_digit(core_result[15:8]) && is_ascii_digit(core_result[7:0]);
  assign line_value = {3'b000, core_result[11:8]} * 7'd10 + {3'b000, core_result[3:0]};

  // Next-state logic; outputs are derived from the next state so they register in step with it.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    settle_cnt_d = settle_cnt_q;
    last_seen_d  = last_seen_q;
    sum_d        = sum_q;
    line_count_d = line_count_q;
    err_count_d  = err_count_q;
    trunc_d      = trunc_q;
    buf_we       = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (xfer) begin
          if (s_last) begin
            last_seen_d = 1'b1;
          end else begin
            last_seen_d = last_seen_q;
          end
          if ((s_data != CHAR_CR) && (s_data != CHAR_LF)) begin
            if (wr_ptr_q == MAX_PTR) begin
              trunc_d = 1'b1;
            end else begin
              buf_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
          end else begin
            wr_ptr_d = wr_ptr_q;
          end
          if ((s_data == CHAR_LF) || s_last) begin
            if (wr_ptr_d == '0) begin
              state_d = last_seen_d ? ST_DONE : ST_LOAD;
            end else begin
              state_d = ST_CLEAR;
            end
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_CLEAR: begin
        rd_ptr_d = '0;
        state_d  = ST_FEED;
      end
      ST_FEED: begin
        if ((rd_ptr_q + PTR_ONE) == wr_ptr_q) begin
          settle_cnt_d = 4'd0;
          state_d      = ST_SETTLE;
        end else begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = ST_CAPTURE;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      ST_CAPTURE: begin
        if (result_ok) begin
          sum_d = sum_q + SUM_W'(line_value);
        end else if (err_count_q != CNT_MAX) begin
          err_count_d = err_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          err_count_d = err_count_q;
        end
        if (line_count_q != CNT_MAX) begin
          line_count_d = line_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          line_count_d = line_count_q;
        end
        wr_ptr_d = '0;
        state_d  = last_seen_q ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase

    s_ready_d = (state_d == ST_LOAD);
    done_d    = (state_d == ST_DONE);
    busy_d    = !(((state_d == ST_LOAD) && (wr_ptr_d == '0)) || (state_d == ST_DONE));

    // In LOAD the core keeps its last result, so its reset is simply held.
    case (state_d)
      ST_LOAD:    begin core_rst_n_d = core_rst_n_q; core_char_d = 8'h00; end
      ST_CLEAR:   begin core_rst_n_d = 1'b0;         core_char_d = 8'h00; end
      ST_FEED:    begin core_rst_n_d = 1'b1;         core_char_d = buf_q[rd_ptr_d[IDX_W-1:0]]; end
      ST_SETTLE:  begin core_rst_n_d = 1'b1;         core_char_d = 8'h00; end
      ST_CAPTURE: begin core_rst_n_d = 1'b1;         core_char_d = 8'h00; end
      ST_DONE:    begin core_rst_n_d = 1'b0;         core_char_d = 8'h00; end
      default:    begin core_rst_n_d = 1'b0;         core_char_d = 8'h00; end
    endcase
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      settle_cnt_q <= 4'd0;
      last_seen_q  <= 1'b0;
      sum_q        <= '0;
      line_count_q <= '0;
      err_count_q  <= '0;
      trunc_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      s_ready_q    <= 1'b0;
      core_rst_n_q <= 1'b0;
      core_char_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      settle_cnt_q <= settle_cnt_d;
      last_seen_q  <= last_seen_d;
      sum_q        <= sum_d;
      line_count_q <= line_count_d;
      err_count_q  <= err_count_d;
      trunc_q      <= trunc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      s_ready_q    <= s_ready_d;
      core_rst_n_q <= core_rst_n_d;
      core_char_q  <= core_char_d;
    end
  end

  // Line buffer; contents need no reset because wr_ptr bounds what is replayed.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[wr_ptr_q[IDX_W-1:0]] <= s_data;
    end
  end

  assign s_ready    = s_ready_q;
  assign core_rst_n = core_rst_n_q;
  assign core_char  = core_char_q;
  assign sum_out    = sum_q;
  assign line_count = line_count_q;
  assign err_count  = err_count_q;
  assign trunc_flag = trunc_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_day_line_sequencer.sv
// Bench for day_line_sequencer: a behavioural `day` core per DUT, a line-level model
// of the expected sums, and one compare process watching the selected DUT.
module tb_day_line_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  int          sel;
  int          part_mode;

  logic        s_ready0, s_ready1, core_rst_n0, core_rst_n1, trunc0, trunc1, busy0, busy1, done0, done1;
  logic [7:0]  core_char0, core_char1;
  logic [15:0] core_result0, core_result1;
  logic [31:0] sum0, sum1;
  logic [15:0] line0, line1, err0, err1;

  day_line_sequencer #(.MAX_LINE(64), .SETTLE_CYCLES(1), .SUM_W(32), .CNT_W(16)) u_dut64 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid && (sel == 0)), .s_ready(s_ready0),
    .s_last(s_last), .core_rst_n(core_rst_n0), .core_char(core_char0), .core_result(core_result0),
    .sum_out(sum0), .line_count(line0), .err_count(err0), .trunc_flag(trunc0), .busy(busy0), .done(done0));

  day_line_sequencer #(.MAX_LINE(8), .SETTLE_CYCLES(2), .SUM_W(32), .CNT_W(16)) u_dut8 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid && (sel == 1)), .s_ready(s_ready1),
    .s_last(s_last), .core_rst_n(core_rst_n1), .core_char(core_char1), .core_result(core_result1),
    .sum_out(sum1), .line_count(line1), .err_count(err1), .trunc_flag(trunc1), .busy(busy1), .done(done1));

  int passed = 0;
  int total  = 0;

  typedef struct {
    longint sum;
    int     lines;
    int     errs;
    string  fed;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic check_str(input string name, input string act, input string req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, req);
  endtask

  function automatic string digit_word(input int d);
    case (d)
      1: return "one";   2: return "two";   3: return "three";
      4: return "four";  5: return "five";  6: return "six";
      7: return "seven"; 8: return "eight"; 9: return "nine";
      default: return "";
    endcase
  endfunction

  function automatic int digit_at(input string s, input int i, input int part);
    logic [7:0] c;
    string w;
    c = s[i];
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (part == 2) begin
      for (int d = 1; d <= 9; d++) begin
        w = digit_word(d);
        if (i + w.len() <= s.len() && s.substr(i, i + w.len() - 1) == w) return d;
      end
    end
    return -1;
  endfunction

  // `day` core behaviour: first and last digit as ASCII, 0x0000 when the line has none.
  function automatic logic [15:0] core_fn(input string s, input int part);
    int first = -1;
    int last  = -1;
    int d;
    for (int i = 0; i < s.len(); i++) begin
      d = digit_at(s, i, part);
      if (d >= 0) begin
        if (first < 0) first = d;
        last = d;
      end
    end
    if (first < 0) return 16'h0000;
    return {8'(8'h30 + first), 8'(8'h30 + last)};
  endfunction

  string cstr0 = "";
  string cstr1 = "";
  always @(posedge clk) begin
    if (!core_rst_n0) cstr0 = "";
    else if (core_char0 != 8'h00) cstr0 = $sformatf("%s%c", cstr0, core_char0);
    core_result0 <= core_fn(cstr0, part_mode);
  end
  always @(posedge clk) begin
    if (!core_rst_n1) cstr1 = "";
    else if (core_char1 != 8'h00) cstr1 = $sformatf("%s%c", cstr1, core_char1);
    core_result1 <= core_fn(cstr1, part_mode);
  end

  // Expected per-line results from the raw stream: strip CR, split, drop empties, truncate.
  task automatic model_stream(input string s, input bit with_last, input int ml,
                              output longint msum, output bit mtrunc);
    string       cur = "";
    longint      sum = 0;
    int          lines = 0, errs = 0;
    logic [7:0]  c;
    logic [15:0] r;
    bit          last;
    exp_t        e;
    mtrunc = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      last = with_last && (i == s.len() - 1);
      if (c != 8'h0d && c != 8'h0a) begin
        if (cur.len() < ml) cur = $sformatf("%s%c", cur, c);
        else mtrunc = 1'b1;
      end
      if ((c == 8'h0a || last) && cur.len() > 0) begin
        r = core_fn(cur, part_mode);
        if (r[15:8] >= 8'h30 && r[15:8] <= 8'h39 && r[7:0] >= 8'h30 && r[7:0] <= 8'h39)
          sum += (longint'(r[15:8]) - 48) * 10 + (longint'(r[7:0]) - 48);
        else
          errs++;
        lines++;
        e.sum = sum; e.lines = lines; e.errs = errs; e.fed = cur;
        exp_q.push_back(e);
        cur = "";
      end
    end
    msum = sum;
  endtask

  // Compare process: every line-count step is checked against the model, plus feed content.
  string fed = "";
  bit    gap = 1'b0;
  bit    prev_rstn = 1'b0;
  int    rises = 0;
  logic [15:0] prev_line = 16'd0;
  always @(negedge clk) begin
    logic        c_rstn;
    logic [7:0]  c_char;
    logic [31:0] c_sum;
    logic [15:0] c_line, c_err;
    exp_t        e;
    c_rstn = (sel == 1) ? core_rst_n1 : core_rst_n0;
    c_char = (sel == 1) ? core_char1  : core_char0;
    c_sum  = (sel == 1) ? sum1  : sum0;
    c_line = (sel == 1) ? line1 : line0;
    c_err  = (sel == 1) ? err1  : err0;
    if (rst) begin
      prev_line = 16'd0; fed = ""; gap = 1'b0; prev_rstn = 1'b0; rises = 0;
    end else begin
      if (c_line != prev_line) begin
        if (exp_q.size() == 0) begin
          check("unexpected_line", longint'(c_line), longint'(prev_line));
        end else begin
          e = exp_q.pop_front();
          check("line_sum", longint'(c_sum), e.sum);
          check("line_count", longint'(c_line), longint'(e.lines));
          check("line_err", longint'(c_err), longint'(e.errs));
          check("core_resets", longint'(rises), longint'(e.lines));
          check_str("fed_chars", fed, e.fed);
        end
        prev_line = c_line;
      end
      if (!c_rstn) begin
        fed = ""; gap = 1'b0;
      end else if (c_char != 8'h00) begin
        if (gap) check("feed_gap", longint'(c_char), 0);
        fed = $sformatf("%s%c", fed, c_char);
      end else if (fed.len() > 0) begin
        gap = 1'b1;
      end
      if (c_rstn && !prev_rstn) rises++;
      prev_rstn = c_rstn;
    end
  end

  function automatic logic ready_sel();
    return (sel == 1) ? s_ready1 : s_ready0;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    exp_q.delete();
    tick();
    check("rst_sum",   longint'((sel == 1) ? sum1 : sum0), 0);
    check("rst_lines", longint'((sel == 1) ? line1 : line0), 0);
    check("rst_errs",  longint'((sel == 1) ? err1 : err0), 0);
    check("rst_trunc", longint'((sel == 1) ? trunc1 : trunc0), 0);
    check("rst_done",  longint'((sel == 1) ? done1 : done0), 0);
    check("rst_core_rst_n", longint'((sel == 1) ? core_rst_n1 : core_rst_n0), 0);
    check("rst_core_char",  longint'((sel == 1) ? core_char1 : core_char0), 0);
    check("rst_s_ready", longint'(ready_sel()), 0);
    rst = 1'b0;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit l);
    int n = 0;
    repeat ($urandom_range(0, 2)) tick();
    s_data = b; s_last = l; s_valid = 1'b1;
    while (!ready_sel()) begin
      tick();
      n++;
      if (n > 500) begin
        check("s_ready_timeout", n, 0);
        s_valid = 1'b0; s_last = 1'b0;
        return;
      end
    end
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_stream(input string s, input bit with_last);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], with_last && (i == s.len() - 1));
  endtask

  task automatic finish_test(input string name, input longint xsum, input int xlines,
                             input int xerrs, input bit xtrunc);
    int n = 0;
    while (!((sel == 1) ? done1 : done0) && n < 3000) begin tick(); n++; end
    repeat (3) tick();
    check({name, "_done"},  longint'((sel == 1) ? done1 : done0), 1);
    check({name, "_sum"},   longint'((sel == 1) ? sum1 : sum0), xsum);
    check({name, "_lines"}, longint'((sel == 1) ? line1 : line0), longint'(xlines));
    check({name, "_errs"},  longint'((sel == 1) ? err1 : err0), longint'(xerrs));
    check({name, "_trunc"}, longint'((sel == 1) ? trunc1 : trunc0), longint'(xtrunc));
    check({name, "_busy"},  longint'((sel == 1) ? busy1 : busy0), 0);
    check({name, "_ready"}, longint'(ready_sel()), 0);
    check({name, "_pending"}, longint'(exp_q.size()), 0);
  endtask

  task automatic run_test(input string name, input string s, input bit with_last, input int dut,
                          input int part, input longint xsum, input int xlines, input int xerrs,
                          input bit xtrunc);
    longint msum;
    bit     mtrunc;
    sel = dut; part_mode = part;
    do_reset();
    model_stream(s, with_last, (dut == 1) ? 8 : 64, msum, mtrunc);
    check({name, "_model_sum"}, msum, xsum);
    check({name, "_model_trunc"}, longint'(mtrunc), longint'(xtrunc));
    send_stream(s, with_last);
    finish_test(name, xsum, xlines, xerrs, xtrunc);
  endtask

  initial begin
    longint msum;
    bit     mtrunc;
    int     n;
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; sel = 0; part_mode = 1;
    tick();

    run_test("part1", "1abc2\npqr3stu8vwx\na1b2c3d4e5f\ntreb7uchet", 1'b1, 0, 1, 142, 4, 0, 1'b0);
    run_test("part2", "two1nine\neightwothree\nabcone2threexyz\n", 1'b1, 0, 2, 125, 3, 0, 1'b0);
    run_test("empty", "12\n\n\015\n34\n", 1'b1, 0, 1, 46, 2, 0, 1'b0);
    run_test("trunc", "a1bcdefgh9\n", 1'b1, 1, 1, 11, 1, 0, 1'b1);
    run_test("nodigit", "abc\n", 1'b1, 0, 1, 0, 1, 1, 1'b0);

    // Abort a line mid-feed with reset; only the following line may count.
    sel = 0; part_mode = 1;
    do_reset();
    send_stream("5x5\n", 1'b0);
    n = 0;
    while (!core_rst_n0 && n < 200) begin tick(); n++; end
    check("abort_reached_feed", longint'(core_rst_n0), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    tick();
    model_stream("77\n", 1'b1, 64, msum, mtrunc);
    check("abort_model_sum", msum, 77);
    send_stream("77\n", 1'b1);
    finish_test("abort", 77, 1, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
